// File: rtl/sprinkler_pump_sequencer_if.sv
// rtl/sprinkler_pump_sequencer_if.sv - request/interlock inputs and actuator/status outputs of the pump sequencer
interface sprinkler_pump_sequencer_if;
    logic       sprinkler_request;
    logic       water_empty;
    logic       fault_clear;
    logic       valve_open;
    logic       pump_on;
    logic       fault;
    logic [2:0] state;
    logic [7:0] cycles_done;

    modport master (
        output sprinkler_request, water_empty, fault_clear,
        input  valve_open, pump_on, fault, state, cycles_done
    );

    modport slave (
        input  sprinkler_request, water_empty, fault_clear,
        output valve_open, pump_on, fault, state, cycles_done
    );
endinterface

// File: rtl/sprinkler_pump_sequencer.sv
// rtl/sprinkler_pump_sequencer.sv - tick-timed valve/pump sequencer with dry-run fault lockout
module sprinkler_pump_sequencer #(
    parameter int CLK_DIV     = 50000000,
    parameter int OPEN_DELAY  = 2,
    parameter int MIN_ON      = 10,
    parameter int MAX_ON      = 600,
    parameter int CLOSE_DELAY = 2,
    parameter int COOLDOWN    = 60,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    sprinkler_pump_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPEN  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CLOSE = 3'd3,
        ST_COOL  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam int PS_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_DELAY - 1);
    localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_DELAY - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] MIN_HOLD   = CNT_W'(MIN_ON);

    state_t           state_q, state_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [7:0]       cycles_q, cycles_d;
    logic             tick;

    // Prescaler free-runs across state changes, so the first tick in a state may be partial.
    assign tick    = (presc_q == PS_LAST);
    assign presc_d = tick ? '0 : presc_q + PS_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            timer_q  <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            timer_q  <= timer_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.sprinkler_request && !bus.water_empty) state_d = ST_OPEN;
            end
            ST_OPEN: begin
                if (bus.water_empty)                   state_d = ST_FAULT;
                else if (!bus.sprinkler_request)       state_d = ST_CLOSE;
                else if (tick && timer_q == OPEN_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.water_empty) begin
                    state_d = ST_FAULT;
                end else if ((tick && timer_q == MAX_LAST) ||
                             (!bus.sprinkler_request && timer_q >= MIN_HOLD)) begin
                    state_d = ST_CLOSE;
                    if (cycles_q != 8'hFF) cycles_d = cycles_q + 8'd1;
                end
            end
            ST_CLOSE: begin
                if (tick && timer_q == CLOSE_LAST) state_d = ST_COOL;
            end
            ST_COOL: begin
                if (tick && timer_q == COOL_LAST) state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (bus.fault_clear && !bus.water_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) timer_d = '0;
        else if (tick)          timer_d = timer_q + CNT_W'(1);
        else                    timer_d = timer_q;
    end

    // Decoded straight from the async-reset state register, so reset drops the actuators without a clock.
    assign bus.valve_open  = (state_q == ST_OPEN) || (state_q == ST_RUN) || (state_q == ST_CLOSE);
    assign bus.pump_on     = (state_q == ST_RUN);
    assign bus.fault       = (state_q == ST_FAULT);
    assign bus.state       = state_q;
    assign bus.cycles_done = cycles_q;

endmodule

// File: tb/tb_sprinkler_pump_sequencer.sv
// tb/tb_sprinkler_pump_sequencer.sv - vector table, directed sequences and random run against a tick-count model
module tb_sprinkler_pump_sequencer;
    localparam int CLK_DIV     = 4;
    localparam int OPEN_DELAY  = 2;
    localparam int MIN_ON      = 3;
    localparam int MAX_ON      = 6;
    localparam int CLOSE_DELAY = 1;
    localparam int COOLDOWN    = 2;
    localparam int CNT_W       = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprinkler_pump_sequencer_if sif();

    sprinkler_pump_sequencer #(
        .CLK_DIV(CLK_DIV), .OPEN_DELAY(OPEN_DELAY), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON),
        .CLOSE_DELAY(CLOSE_DELAY), .COOLDOWN(COOLDOWN), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(sif)
    );

    typedef struct {
        bit       req;
        bit       we;
        bit       fc;
        bit [2:0] st;
        bit       valve;
        bit       pump;
        bit       flt;
    } vec_t;

    vec_t tbl[14];

    int checks   = 0;
    int failures = 0;

    // Model: phase code, ticks counted in the phase, clock position within a tick period.
    int m_phase;
    int m_ticks;
    int m_div;
    int m_cycles;
    int m_runs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase  = 0;
        m_ticks  = 0;
        m_div    = 0;
        m_cycles = 0;
    endfunction

    function automatic void model_step(input bit r, input bit w, input bit c);
        bit tk;
        int n;
        int nxt;
        tk  = (m_div == CLK_DIV - 1);
        n   = m_ticks + (tk ? 1 : 0);
        nxt = m_phase;
        case (m_phase)
            0: if (r && !w) nxt = 1;
            1: begin
                if (w) nxt = 5;
                else if (!r) nxt = 3;
                else if (tk && n == OPEN_DELAY) nxt = 2;
            end
            2: begin
                if (w) nxt = 5;
                else if ((tk && n == MAX_ON) || (!r && m_ticks >= MIN_ON)) begin
                    nxt = 3;
                    m_runs++;
                    if (m_cycles < 255) m_cycles++;
                end
            end
            3: if (tk && n == CLOSE_DELAY) nxt = 4;
            4: if (tk && n == COOLDOWN) nxt = 0;
            5: if (c && !w) nxt = 0;
            default: nxt = 0;
        endcase
        m_ticks = (nxt != m_phase) ? 0 : n;
        m_phase = nxt;
        m_div   = tk ? 0 : m_div + 1;
    endfunction

    task automatic compare_model();
        check("state", sif.state, m_phase);
        check("valve_open", sif.valve_open, (m_phase >= 1 && m_phase <= 3) ? 1 : 0);
        check("pump_on", sif.pump_on, (m_phase == 2) ? 1 : 0);
        check("fault", sif.fault, (m_phase == 5) ? 1 : 0);
        check("cycles_done", sif.cycles_done, m_cycles);
        check("pump_implies_valve", sif.pump_on & ~sif.valve_open, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step(sif.sprinkler_request, sif.water_empty, sif.fault_clear);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sif.sprinkler_request = 1'b0;
        sif.water_empty       = 1'b0;
        sif.fault_clear       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_state(input logic [2:0] code, input int budget, input string name);
        bit hit;
        hit = 0;
        for (int k = 0; k < budget && !hit; k++) begin
            step();
            if (sif.state == code) hit = 1;
        end
        check(name, hit, 1);
    endtask

    initial begin
        int  pump_cycles;
        bit  seen_cool;
        bit  done;

        tbl[0]  = '{1, 0, 0, 3'd1, 1, 0, 0};
        tbl[1]  = '{0, 0, 0, 3'd3, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 3'd3, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 3'd4, 0, 0, 0};
        for (int i = 4; i <= 10; i++) tbl[i] = '{0, 0, 0, 3'd4, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 3'd0, 0, 0, 0};
        tbl[12] = '{1, 1, 0, 3'd0, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 3'd0, 0, 0, 0};
        m_runs = 0;

        do_reset();
        check("reset_state", sif.state, 0);
        check("reset_valve", sif.valve_open, 0);
        check("reset_pump", sif.pump_on, 0);
        check("reset_fault", sif.fault, 0);
        check("reset_cycles", sif.cycles_done, 0);

        // Single-cycle request pulse, then request while the reservoir is empty.
        for (int i = 0; i < 14; i++) begin
            sif.sprinkler_request = tbl[i].req;
            sif.water_empty       = tbl[i].we;
            sif.fault_clear       = tbl[i].fc;
            step();
            check($sformatf("tbl%0d_state", i), sif.state, tbl[i].st);
            check($sformatf("tbl%0d_valve", i), sif.valve_open, tbl[i].valve);
            check($sformatf("tbl%0d_pump", i), sif.pump_on, tbl[i].pump);
            check($sformatf("tbl%0d_fault", i), sif.fault, tbl[i].flt);
        end
        check("tbl_cycles", sif.cycles_done, 0);

        // Request held: full cycle runs to MAX_ON.
        do_reset();
        sif.sprinkler_request = 1'b1;
        pump_cycles = 0;
        seen_cool   = 0;
        done        = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            step();
            if (k == 0) check("t1_valve_first", sif.valve_open, 1);
            if (sif.pump_on) pump_cycles++;
            if (sif.state == 3'd4) seen_cool = 1;
            if (seen_cool && sif.state == 3'd0) done = 1;
        end
        sif.sprinkler_request = 1'b0;
        check("t1_reached_idle", done, 1);
        check("t1_pump_cycles", pump_cycles, MAX_ON * CLK_DIV);
        check("t1_cycles_done", sif.cycles_done, 1);

        // Early request drop is held off until MIN_ON ticks in RUN.
        sif.sprinkler_request = 1'b1;
        wait_state(3'd2, 100, "t3_enter_run");
        pump_cycles = 1;
        for (int k = 0; k < 100 && m_ticks < 1; k++) begin
            step();
            if (sif.pump_on) pump_cycles++;
        end
        sif.sprinkler_request = 1'b0;
        for (int k = 0; k < 100 && sif.state == 3'd2; k++) begin
            step();
            if (sif.pump_on) pump_cycles++;
        end
        check("t3_state_close", sif.state, 3);
        check("t3_pump_cycles", pump_cycles, MIN_ON * CLK_DIV + 1);
        check("t3_cycles_done", sif.cycles_done, 2);
        wait_state(3'd0, 100, "t3_back_idle");

        // Dry run during RUN, then acknowledge with and without water.
        sif.sprinkler_request = 1'b1;
        wait_state(3'd2, 100, "t4_enter_run");
        sif.water_empty = 1'b1;
        step();
        check("t4_state_fault", sif.state, 5);
        check("t4_pump_off", sif.pump_on, 0);
        check("t4_fault", sif.fault, 1);
        sif.fault_clear = 1'b1;
        repeat (3) step();
        check("t4_clear_ignored", sif.state, 5);
        check("t4_fault_held", sif.fault, 1);
        sif.water_empty = 1'b0;
        step();
        check("t4_state_idle", sif.state, 0);
        check("t4_fault_clr", sif.fault, 0);
        check("t4_cycles_same", sif.cycles_done, 2);
        sif.fault_clear       = 1'b0;
        sif.sprinkler_request = 1'b0;
        step();

        // Asynchronous reset mid-RUN.
        sif.sprinkler_request = 1'b1;
        wait_state(3'd2, 100, "t5_enter_run");
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_pump", sif.pump_on, 0);
        check("t5_async_valve", sif.valve_open, 0);
        check("t5_async_state", sif.state, 0);
        check("t5_async_cycles", sif.cycles_done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step();
        check("t5_fresh_open", sif.state, 1);
        check("t5_fresh_valve", sif.valve_open, 1);

        // Saturation over 257 completed cycles with request held through COOL.
        do_reset();
        sif.sprinkler_request = 1'b1;
        m_runs = 0;
        for (int k = 0; k < 20000 && m_runs < 257; k++) step();
        check("t6_runs_reached", m_runs, 257);
        check("t6_saturated", sif.cycles_done, 255);
        wait_state(3'd4, 200, "t6_enter_cool");
        wait_state(3'd0, 200, "t6_back_idle");
        step();
        check("t6_reopen", sif.state, 1);

        // Randomized request/interlock/acknowledge traffic.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0)  sif.sprinkler_request = ~sif.sprinkler_request;
            if ($urandom_range(0, 59) == 0) sif.water_empty = ~sif.water_empty;
            sif.fault_clear = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
